mole_spawner: RTL and testbench
===============================

// Module: mole_spawner
// PURPOSE
//  Whack-a-mole game engine: produces the mole_hit pulse consumed by the score counter.
//  Picks a pseudo-random hole, lights its LED for a bounded window, watches player buttons,
//  and emits one-cycle mole_hit / mole_miss pulses. Sits between board I/O and scoring.
// PARAMETERS
//  NUM_HOLES      4           holes/buttons/LEDs; power of 2, 2..16
//  MOLE_UP_CYCLES 50_000_000  clk cycles a mole stays up (1 s @ 50 MHz); >= 8
//  GAP_CYCLES     25_000_000  clk cycles between moles; >= 2
//  LFSR_SEED      16'hACE1    LFSR reset value; nonzero
// PORTS
//  clk        in   1          system clock
//  rst_n      in   1          async active-low reset
//  restart    in   1          sync game restart (same signal that clears score)
//  enable     in   1          game running; low parks engine in IDLE
//  buttons    in   NUM_HOLES  raw player buttons, active-high, asynchronous
//  mole_leds  out  NUM_HOLES  one-hot active mole, all-zero when none
//  mole_hit   out  1          1-cycle pulse: correct hole pressed while mole up
//  mole_miss  out  1          1-cycle pulse: mole window expired unhit
// BEHAVIOUR
//  - Reset (rst_n=0): state IDLE, mole_leds=0, mole_hit=0, mole_miss=0, timer=0, LFSR=LFSR_SEED.
//  - Buttons: 2-FF synchroniser per bit, then rising-edge detect on synced value.
//  - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, steps every clk in every state.
//  - FSM: IDLE -> GAP when enable=1. GAP: timer counts GAP_CYCLES, then -> UP.
//    UP entry: hole = LFSR[log2(NUM_HOLES)-1:0]; if equal to previous hole use hole+1 mod
//    NUM_HOLES; mole_leds one-hot valid the first cycle in UP; timer loads up-time.
//    UP: edge on active hole -> mole_hit=1 next cycle, mole_leds=0, -> GAP.
//        timer expiry -> mole_miss=1 next cycle, mole_leds=0, -> GAP.
//  - Hit latency: mole_hit high 3 clk edges after the edge first sampling button high.
//  - Edges on non-active holes ignored; held button gives no further edges (no auto-repeat).
//  - Button edge and timer expiry same cycle: hit wins, no miss.
//  - Edges in GAP/IDLE ignored; a button already held when UP starts does not hit.
//  - mole_hit and mole_miss never high together; at most one pulse per mole.
//  - restart=1 (sync, any state): outputs 0, timer cleared, -> GAP if enable else IDLE;
//    LFSR and previous-hole not reset. restart beats any same-cycle hit.
//  - enable=0 mid-UP: -> IDLE next cycle, mole_leds=0, no hit/miss pulse.
//  - Timers sized $clog2(max(MOLE_UP_CYCLES,GAP_CYCLES)+1); no wrap possible.
// CONFIGURATION
//  SPEEDUP_EN defined: up-time register starts at MOLE_UP_CYCLES, drops by
//   MOLE_UP_CYCLES/8 on each hit, floor MOLE_UP_CYCLES/4; restart/reset reload full value.
//  SPEEDUP_EN undefined: up-time constant MOLE_UP_CYCLES; no up-time register.
// STRUCTURE
//  Package mole_pkg: typedef enum logic [1:0] {IDLE,GAP,UP} mole_state_t; LFSR tap
//   constant; function hole_w(n) = $clog2(n).
//  Sub-module lfsr16 (clk, rst_n, seed param, q[15:0]); rest inline in mole_spawner.
// TESTING (NUM_HOLES=4, MOLE_UP_CYCLES=10, GAP_CYCLES=4)
//  1 Reset then enable=1: leds 0 for 4 cycles, then one-hot, never same hole twice running.
//  2 Press active hole 2 cycles into UP -> mole_hit 1 cycle at +3 edges, leds 0, next GAP 4.
//  3 No press -> mole_miss exactly 1 cycle after 10 UP cycles; mole_hit stays 0.
//  4 Press wrong hole, hold active hole across UP entry -> no hit; release/press -> hit.
//  5 restart mid-UP with same-cycle valid edge -> no pulse, leds 0, GAP restarts from 0.
//  6 SPEEDUP_EN: 7 hits -> up-times 10,9,8,7,6,5,4... floor 2; rst_n low -> back to 10.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole engine.
package mole_pkg;

    typedef enum logic [1:0] {IDLE, GAP, UP} mole_state_t;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int hole_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; advances on every clock.
module lfsr16
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (q[0]) begin
            q <= (q >> 1) ^ LFSR_TAPS;
        end else begin
            q <= q >> 1;
        end
    end

endmodule

// File: rtl/mole_spawner.sv
// Whack-a-mole engine: random hole, up/gap timing, one-cycle hit/miss pulses.
// Define SPEEDUP_EN to shorten the up window after every hit.
module mole_spawner
    import mole_pkg::*;
#(
    parameter int          NUM_HOLES      = 4,
    parameter int          MOLE_UP_CYCLES = 50_000_000,
    parameter int          GAP_CYCLES     = 25_000_000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 restart,
    input  logic                 enable,
    input  logic [NUM_HOLES-1:0] buttons,
    output logic [NUM_HOLES-1:0] mole_leds,
    output logic                 mole_hit,
    output logic                 mole_miss
);

    localparam int HW   = hole_w(NUM_HOLES);
    localparam int TMAX = (MOLE_UP_CYCLES > GAP_CYCLES) ? MOLE_UP_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] UP_FULL  = TW'(MOLE_UP_CYCLES);

    mole_state_t          state;
    logic [TW-1:0]        timer;
    logic [TW-1:0]        up_time;
    logic [HW-1:0]        prev_hole;
    logic [HW-1:0]        pick;
    logic [HW-1:0]        next_hole;
    logic [NUM_HOLES-1:0] sync1;
    logic [NUM_HOLES-1:0] sync2;
    logic [NUM_HOLES-1:0] btn_prev;
    logic [NUM_HOLES-1:0] btn_edge;
    logic [15:0]          lfsr;
    logic                 lfsr_unused;
    logic                 hit_now;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .q    (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:HW];
    assign pick        = lfsr[HW-1:0];
    assign next_hole   = (pick == prev_hole) ? pick + HW'(1) : pick;

    // Edge is registered so a press reaches the FSM three edges after sampling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            btn_prev <= '0;
            btn_edge <= '0;
        end else begin
            sync1    <= buttons;
            sync2    <= sync1;
            btn_prev <= sync2;
            btn_edge <= sync2 & ~btn_prev;
        end
    end

    assign hit_now = (state == UP) && |(mole_leds & btn_edge);

`ifdef SPEEDUP_EN
    localparam logic [TW-1:0] UP_STEP  = TW'(MOLE_UP_CYCLES / 8);
    localparam logic [TW-1:0] UP_FLOOR = TW'(MOLE_UP_CYCLES / 4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_time <= UP_FULL;
        end else if (restart) begin
            up_time <= UP_FULL;
        end else if (enable && hit_now) begin
            up_time <= (up_time >= UP_FLOOR + UP_STEP) ? up_time - UP_STEP : UP_FLOOR;
        end
    end
`else
    assign up_time = UP_FULL;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            prev_hole <= '0;
            mole_leds <= '0;
            mole_hit  <= 1'b0;
            mole_miss <= 1'b0;
        end else begin
            mole_hit  <= 1'b0;
            mole_miss <= 1'b0;
            if (restart || !enable) begin
                state     <= (restart && enable) ? GAP : IDLE;
                timer     <= '0;
                mole_leds <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= GAP;
                        timer <= '0;
                    end
                    GAP: begin
                        if (timer == GAP_LAST) begin
                            state     <= UP;
                            timer     <= '0;
                            prev_hole <= next_hole;
                            mole_leds <= NUM_HOLES'(1) << next_hole;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    UP: begin
                        // a hit landing on the expiry cycle still counts as a hit
                        if (hit_now || timer == up_time - TW'(1)) begin
                            state     <= GAP;
                            timer     <= '0;
                            mole_leds <= '0;
                            mole_hit  <= hit_now;
                            mole_miss <= !hit_now;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        mole_leds <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: scenario table plus hand sequences for
// held buttons, restart, enable drop and mid-game reset.
module tb_mole_spawner;

    localparam int          NH   = 4;
    localparam int          UPC  = 10;
    localparam int          GAPC = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          restart = 1'b0;
    logic          enable  = 1'b0;
    logic [NH-1:0] buttons = '0;
    logic [NH-1:0] mole_leds;
    logic          mole_hit;
    logic          mole_miss;

    mole_spawner #(
        .NUM_HOLES     (NH),
        .MOLE_UP_CYCLES(UPC),
        .GAP_CYCLES    (GAPC),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .enable   (enable),
        .buttons  (buttons),
        .mole_leds(mole_leds),
        .mole_hit (mole_hit),
        .mole_miss(mole_miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit hit;
    } exp_t;

    typedef struct {
        int off;
        bit wrong;
        bit hit;
        int dt;
    } vec_t;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            last_hole;
    logic [15:0]   lfsr_m   = SEED;
    logic [15:0]   lfsr_prev;
    logic [NH-1:0] leds_q;
    exp_t          sb[$];
    vec_t          vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= SEED;
        else        lfsr_m <= lfsr_step(lfsr_m);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at cyc=%0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    function automatic int active();
        int a;
        a = -1;
        for (int i = 0; i < NH; i++) if (mole_leds == (NH'(1) << i)) a = i;
        return a;
    endfunction

    task automatic check_hole();
        int raw;
        int got;
        int want;
        bit ok;
        raw = int'(lfsr_prev[1:0]);
        got = active();
        want = (last_hole >= 0 && raw == last_hole) ? (raw + 1) % NH : raw;
        if (last_hole < 0) ok = (got >= 0) && (got == raw || got == (raw + 1) % NH);
        else               ok = (got >= 0) && (got == want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL hole_pick at cyc=%0d: actual leds=%b required hole=%0d (prev=%0d)",
                     cyc, mole_leds, want, last_hole);
        end
        last_hole = got;
    endtask

    task automatic check_pulses();
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL pulse_missing at cyc=%0d: actual none required %s at cyc=%0d",
                     cyc, e.hit ? "hit" : "miss", e.cyc);
        end
        if (mole_hit || mole_miss) begin
            checks++;
            if (mole_hit && mole_miss) begin
                failures++;
                $display("FAIL pulse_both at cyc=%0d: actual hit=1 miss=1 required one", cyc);
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL pulse_unexpected at cyc=%0d: actual hit=%0d miss=%0d required none",
                         cyc, mole_hit, mole_miss);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.hit != mole_hit) begin
                    failures++;
                    $display("FAIL pulse at cyc=%0d: actual hit=%0d required hit=%0d at cyc=%0d",
                             cyc, mole_hit, e.hit, e.cyc);
                end
            end
        end
    endtask

    // Every wait goes through here so the monitors see each cycle exactly once
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            chk("reset_outputs", {mole_leds, mole_hit, mole_miss}, 0);
            last_hole = -1;
            leds_q = '0;
        end else begin
            if (mole_leds != '0 && leds_q == '0) check_hole();
            check_pulses();
            leds_q = mole_leds;
        end
        lfsr_prev = lfsr_m;
    endtask

    task automatic wait_up(output int u);
        int n;
        n = 0;
        while (mole_leds == '0 && n < 40) begin
            tick();
            n++;
        end
        u = cyc;
        if (mole_leds == '0) begin
            checks++;
            failures++;
            $display("FAIL up_timeout at cyc=%0d: actual leds=0 required a mole", cyc);
        end
    endtask

    task automatic run_row(input int off, input bit wrong, input bit hit, input int dt,
                           input int exp_u, output int nxt);
        int u;
        int h;
        wait_up(u);
        chk("up_start", u, exp_u);
        h = active();
        if (h < 0) h = 0;
        if (wrong) h = (h + 1) % NH;
        if (!hit) sb.push_back('{u + dt, 1'b0});
        while (cyc < u + dt) begin
            if (cyc == u + off) begin
                buttons[h] = 1'b1;
                if (hit) sb.push_back('{u + dt, 1'b1});
            end
            if (cyc == u + off + 2) buttons[h] = 1'b0;
            tick();
        end
        buttons = '0;
        chk("leds_after_pulse", mole_leds, 0);
        nxt = u + dt + GAPC;
    endtask

    initial begin
        int exp_u;
        int nxt;
        int u;
        int h;

        // {press offset into UP (-1 none), wrong hole, expect hit, pulse delay}
        vecs = '{'{1, 1'b0, 1'b1, 5},
                 '{-1, 1'b0, 1'b0, 10},
                 '{0, 1'b0, 1'b1, 4},
                 '{6, 1'b0, 1'b1, 10},
                 '{7, 1'b0, 1'b0, 10},
                 '{2, 1'b1, 1'b0, 10},
                 '{4, 1'b0, 1'b1, 8}};

        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_leds", mole_leds, 0);
        enable = 1'b1;
        exp_u = cyc + 5;

`ifdef SPEEDUP_EN
        for (int k = 0; k < 7; k++) begin
            run_row(-1, 1'b0, 1'b0, UPC - k, exp_u, nxt);
            exp_u = nxt;
            run_row(0, 1'b0, 1'b1, 4, exp_u, nxt);
            exp_u = nxt;
        end
        run_row(-1, 1'b0, 1'b0, UPC - 7, exp_u, nxt);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_u = cyc + 5;
        run_row(-1, 1'b0, 1'b0, UPC, exp_u, nxt);
`else
        for (int i = 0; i < 7; i++) begin
            run_row(vecs[i].off, vecs[i].wrong, vecs[i].hit, vecs[i].dt, exp_u, nxt);
            exp_u = nxt;
        end

        // all buttons held through UP entry must not hit
        buttons = '1;
        wait_up(u);
        chk("hold_up_start", u, exp_u);
        repeat (3) tick();
        chk("hold_no_hit", mole_leds != '0, 1);
        buttons = '0;
        repeat (2) tick();
        h = active();
        if (h < 0) h = 0;
        buttons[h] = 1'b1;
        sb.push_back('{u + 9, 1'b1});
        repeat (2) tick();
        buttons = '0;
        while (cyc < u + 9) tick();
        chk("hold_leds_off", mole_leds, 0);
        exp_u = u + 9 + GAPC;

        // restart on the same edge the press would have hit
        wait_up(u);
        chk("restart_up_start", u, exp_u);
        h = active();
        if (h < 0) h = 0;
        tick();
        buttons[h] = 1'b1;
        repeat (3) tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        buttons = '0;
        chk("restart_leds", mole_leds, 0);
        exp_u = u + 5 + GAPC;

        // enable dropped mid-UP
        wait_up(u);
        chk("disable_up_start", u, exp_u);
        repeat (2) tick();
        enable = 1'b0;
        tick();
        chk("disable_leds", mole_leds, 0);
        repeat (12) tick();
        chk("disable_idle", mole_leds, 0);
        enable = 1'b1;
        exp_u = cyc + 5;
        run_row(3, 1'b0, 1'b1, 7, exp_u, nxt);
        exp_u = nxt;

        // asynchronous reset in the middle of a mole
        wait_up(u);
        chk("reset_up_start", u, exp_u);
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        exp_u = cyc + 5;
        run_row(-1, 1'b0, 1'b0, UPC, exp_u, nxt);
`endif

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
